// File: rtl/ann_mac_engine_if.sv
// Engine-side bundle: start/done handshake, indexed buffer read port, and classification result.
// "master" is the buffer/controller side; "slave" is the MAC engine.
interface ann_mac_engine_if #(
  parameter int N_PIX = 64,
  parameter int N_NEU = 16,
  parameter int DW    = 16
);
  localparam int PW = $clog2(N_PIX);
  localparam int NW = $clog2(N_NEU);
  localparam int IW = $clog2(N_NEU * N_PIX);

  logic          start;
  logic          rd_en;
  logic [PW-1:0] image_idx;
  logic [IW-1:0] weight_idx;
  logic [DW-1:0] image_data;
  logic [DW-1:0] weight_data;
  logic          busy;
  logic          p_done;
  logic [NW-1:0] result_class;
  logic [DW-1:0] result_score;

  modport master (
    output start, image_data, weight_data,
    input  rd_en, image_idx, weight_idx, busy, p_done, result_class, result_score
  );

  modport slave (
    input  start, image_data, weight_data,
    output rd_en, image_idx, weight_idx, busy, p_done, result_class, result_score
  );
endinterface

// File: rtl/ann_mac_engine.sv
// 16-neuron Q8.8 MAC with ReLU/saturation and argmax; p_done N_NEU*(N_PIX+2)+1 cycles after start.
// No backpressure: buffers must return data exactly one cycle after rd_en; start ignored unless idle.
module ann_mac_engine #(
  parameter int N_PIX = 64,
  parameter int N_NEU = 16,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  ann_mac_engine_if.slave  bus
);
  localparam int PW = $clog2(N_PIX);
  localparam int NW = $clog2(N_NEU);
  localparam int IW = $clog2(N_NEU * N_PIX);
  localparam logic signed [ACC_W-1:0] SCORE_MAX = ACC_W'((1 << (DW - 1)) - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, STORE, DONE} state_t;

  state_t                   state, state_n;
  logic [PW-1:0]            pix;
  logic [NW-1:0]            neu;
  logic signed [ACC_W-1:0]  acc;
  logic                     vld_d;
  logic [DW-1:0]            best_score, best_score_n;
  logic [NW-1:0]            best_class, best_class_n;
  logic                     rd_en_q, busy_q, p_done_q;
  logic [NW-1:0]            res_class;
  logic [DW-1:0]            res_score;

  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  shifted;
  logic [DW-1:0]            v;

  assign prod = $signed(bus.image_data) * $signed(bus.weight_data);

  always_comb begin
    state_n      = state;
    shifted      = acc >>> FRAC;
    v            = '0;
    best_score_n = best_score;
    best_class_n = best_class;

    if (shifted < 0)
      v = '0;
    else if (shifted > SCORE_MAX)
      v = SCORE_MAX[DW-1:0];
    else
      v = shifted[DW-1:0];

    // Strict compare keeps the lowest-index neuron on ties
    if (state == STORE && v > best_score) begin
      best_score_n = v;
      best_class_n = neu;
    end

    case (state)
      IDLE:    if (bus.start) state_n = FETCH;
      FETCH:   if (pix == PW'(N_PIX - 1)) state_n = DRAIN;
      DRAIN:   state_n = STORE;
      STORE:   state_n = (neu == NW'(N_NEU - 1)) ? DONE : FETCH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix        <= '0;
      neu        <= '0;
      acc        <= '0;
      vld_d      <= 1'b0;
      best_score <= '0;
      best_class <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      p_done_q   <= 1'b0;
      res_class  <= '0;
      res_score  <= '0;
    end else begin
      state    <= state_n;
      rd_en_q  <= (state_n == FETCH);
      busy_q   <= (state_n != IDLE);
      p_done_q <= (state_n == DONE);
      vld_d    <= rd_en_q;

      if (vld_d)
        acc <= acc + {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};

      case (state)
        IDLE: if (bus.start) begin
          pix        <= '0;
          neu        <= '0;
          acc        <= '0;
          best_score <= '0;
          best_class <= '0;
        end
        FETCH: pix <= pix + 1'b1;
        STORE: begin
          best_score <= best_score_n;
          best_class <= best_class_n;
          acc        <= '0;
          pix        <= '0;
          if (state_n == DONE) begin
            res_class <= best_class_n;
            res_score <= best_score_n;
          end else begin
            neu <= neu + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en        = rd_en_q;
  assign bus.image_idx    = pix;
  assign bus.weight_idx   = IW'(neu) * IW'(N_PIX) + IW'(pix);
  assign bus.busy         = busy_q;
  assign bus.p_done       = p_done_q;
  assign bus.result_class = res_class;
  assign bus.result_score = res_score;
endmodule

// File: tb/tb_ann_mac_engine.sv
// Directed bench for ann_mac_engine: buffer model with 1-cycle read latency, hand-computed results.
module tb_ann_mac_engine;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] img [64];
  logic [15:0] wt  [1024];

  ann_mac_engine_if #(.N_PIX(64), .N_NEU(16), .DW(16)) bus ();

  ann_mac_engine #(.N_PIX(64), .N_NEU(16), .DW(16), .FRAC(8), .ACC_W(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.image_data  <= img[bus.image_idx];
      bus.weight_data <= wt[bus.weight_idx];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill(input logic [15:0] pval, input logic [15:0] wval);
    for (int i = 0; i < 64; i++) img[i] = pval;
    for (int i = 0; i < 1024; i++) wt[i] = wval;
  endtask

  // Start in cycle 0, observe cycles 1..1070 at the falling edge.
  // re_at: extra start pulse in that cycle; rst_at: reset pulse in that cycle (-1 = none).
  task automatic run_case(input string tag, input int re_at, input int rst_at, input int exp_done,
                          input logic [3:0] exp_cls, input logic [15:0] exp_scr, input bit sweep);
    int done_cnt = 0;
    int done_at  = -1;
    int rd_cnt   = 0;
    int bad      = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 1070; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      rst = 1'b0;
      if (bus.p_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (bus.rd_en && k <= 1057) begin
        if (bus.weight_idx != 10'(rd_cnt) || bus.image_idx != 6'(rd_cnt % 64)) bad++;
        rd_cnt++;
      end
      if (k == 1) chk({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
      if (k == rst_at + 1) begin
        chk({tag, "_busy_after_rst"}, 32'(bus.busy), 32'd0);
        chk({tag, "_rd_en_after_rst"}, 32'(bus.rd_en), 32'd0);
      end
      if (re_at >= 1058 && k == re_at + 1) begin
        chk({tag, "_b2b_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_b2b_rd_en"}, 32'(bus.rd_en), 32'd1);
      end
      if (k == re_at) bus.start = 1'b1;
      if (k == rst_at) rst = 1'b1;
    end
    if (exp_done > 0) begin
      chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    end else begin
      chk({tag, "_no_done"}, 32'(done_cnt), 32'd0);
    end
    chk({tag, "_class"}, 32'(bus.result_class), 32'(exp_cls));
    chk({tag, "_score"}, 32'(bus.result_score), 32'(exp_scr));
    if (sweep) begin
      chk({tag, "_rd_count"}, 32'(rd_cnt), 32'd1024);
      chk({tag, "_idx_order_bad"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    fill(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_p_done", 32'(bus.p_done), 32'd0);
    chk("rst_class", 32'(bus.result_class), 32'd0);
    chk("rst_score", 32'(bus.result_score), 32'd0);
    rst = 1'b0;

    // Neuron k weights 0x0010*k, pixels 1.0: neuron 15 wins at 0x3C00; restart right after DONE
    fill(16'h0100, 16'h0000);
    for (int n = 0; n < 16; n++)
      for (int p = 0; p < 64; p++) wt[n*64 + p] = 16'(16'h0010 * n);
    run_case("ramp", 1058, -1, 1057, 4'd15, 16'h3C00, 1'b1);
    do_reset();

    fill(16'h0100, 16'h0100);
    run_case("ties", -1, -1, 1057, 4'd0, 16'h4000, 1'b0);
    do_reset();

    fill(16'h0100, 16'hFF00);
    run_case("relu", -1, -1, 1057, 4'd0, 16'h0000, 1'b0);
    do_reset();

    fill(16'h7F00, 16'h7F00);
    run_case("sat", -1, -1, 1057, 4'd0, 16'h7FFF, 1'b0);
    do_reset();

    fill(16'h0000, 16'h0000);
    img[5] = 16'h0300;
    wt[9*64 + 5] = 16'h0200;
    run_case("single", -1, -1, 1057, 4'd9, 16'h0600, 1'b0);
    do_reset();

    run_case("repulse", 500, -1, 1057, 4'd9, 16'h0600, 1'b0);
    run_case("midrst", -1, 300, 0, 4'd0, 16'h0000, 1'b0);
    run_case("fresh", -1, -1, 1057, 4'd9, 16'h0600, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ann_mac_engine.md
Name: ann_mac_engine

Overview:
- Neural-network compute stage directly downstream of the SRAM wrapper/buffer.
- Once the image and weight buffers report loaded, it reads the 64-pixel image and the 16x64 weight matrix from them through indexed read ports.
- It computes 16 fixed-point neuron sums with ReLU and saturation, then selects the winning class by argmax.
- It returns the done pulse (p_done) that the SRAM controller consumes.

Parameters:
- N_PIX, 64: pixels per image and weights per neuron.
- N_NEU, 16: number of output neurons/classes.
- DW, 16: data width; signed Q8.8.
- FRAC, 8: fractional bits of DW data.
- ACC_W, 40: accumulator width; signed.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begin a classification (buffers loaded).
- rd_en  out  1  read strobe to the buffers; high in every FETCH cycle.
- image_idx  out  log2(N_PIX)  pixel index into the image buffer.
- weight_idx  out  log2(N_NEU*N_PIX)  weight index = neuron*N_PIX + pixel.
- image_data  in  DW  pixel word; valid the cycle after rd_en.
- weight_data  in  DW  weight word; valid the cycle after rd_en.
- busy  out  1  high from the cycle after start through the DONE cycle.
- p_done  out  1  one-cycle pulse; results valid.
- result_class  out  log2(N_NEU)  argmax neuron index.
- result_score  out  DW  winning neuron output, Q8.8, >= 0.

Behaviour:
- Reset (sync, rst=1 at a clk edge) forces the following. Mid-operation reset abandons the run with no p_done.
  - state=IDLE; all counters and accumulator = 0.
  - rd_en=0, busy=0, p_done=0, result_class=0, result_score=0.
  - Internal best-so-far registers = 0.
- States: IDLE, FETCH, DRAIN, STORE, DONE.
- IDLE: start=1 moves to FETCH with pix=0, neu=0, acc=0, best_score=0, best_class=0.
- start is ignored in every state other than IDLE.
- FETCH:
  - rd_en=1, image_idx=pix, weight_idx=neu*N_PIX+pix; these are registered outputs driven from the counters.
  - One cycle after each read, the full-precision product image_data*weight_data (2*DW signed) is sign-extended and added to acc.
  - pix increments each cycle. After the cycle issuing pix=N_PIX-1, go to DRAIN.
- DRAIN: rd_en=0; the last product is added; go to STORE.
- STORE:
  - v = acc >>> FRAC (arithmetic shift).
  - If v<0, v=0 (ReLU). If v>2^(DW-1)-1, v=0x7FFF (saturate).
  - If v > best_score (strictly greater), update best_score=v, best_class=neu. Ties keep the lower index.
  - Clear acc and set pix=0.
  - If neu=N_NEU-1, go to DONE; else neu++ and go to FETCH.
- DONE:
  - p_done=1 for exactly this cycle.
  - result_class and result_score load best_class and best_score on entry to DONE and hold until the next start is accepted.
  - Go to IDLE.
- Latency (start high in cycle 0):
  - Neuron n occupies cycles 66n+1 .. 66n+66.
  - p_done is high in cycle N_NEU*(N_PIX+2)+1, which is 1057 for the defaults.
  - Back-to-back: start is accepted again in the cycle after DONE.
- Arithmetic: the accumulator never wraps at the defaults. Worst case is 64 * 2^30 < 2^39.
- Read ports assume exactly 1-cycle read latency; no stall input.

Test Plan:
- Defaults, all pixels 0x0100 (1.0), neuron k weights 0x0010*k -> p_done at cycle 1057, result_class=15, result_score=0x3C00. Check weight_idx sweeps 0..1023 in order with rd_en.
- All weights 0x0100, pixels 0x0100 (every neuron = 64.0 = 0x4000) -> ties, result_class=0, result_score=0x4000.
- All weights 0xFF00 (-1.0), pixels 0x0100 -> all sums negative, ReLU -> result_class=0, result_score=0x0000.
- Pixels 0x7F00, weights 0x7F00 -> every neuron saturates to 0x7FFF -> result_class=0, result_score=0x7FFF.
- Only neuron 9 weight[5]=0x0200 (others 0), pixel[5]=0x0300 -> result_class=9, result_score=0x0600.
- start re-pulsed at cycle 500 -> ignored, single p_done at 1057. rst=1 at cycle 300 -> next cycle busy=0, rd_en=0, no p_done. A fresh start then completes normally 1057 cycles later.
